// File: rtl/avalon_copier_pkg.sv
// Shared types and constants for the Avalon-MM word copier.
package avalon_copier_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RD,
    RD_WAIT,
    WR,
    FIN
  } state_t;

  localparam int         BYTES_PER_WORD = 4;
  localparam logic [3:0] BYTEENABLE_ALL = 4'b1111;

endpackage

// File: rtl/copier_fifo.sv
// Synchronous FIFO that buffers one chunk of read data before it is written back.
module copier_fifo #(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 8,
  localparam int PTR_W  = $clog2(DEPTH),
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] pop_data,
  output logic              empty,
  output logic              full,
  output logic [CNT_W-1:0]  count
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [CNT_W-1:0]  count_q;

  // Pointer and occupancy bookkeeping; pointers wrap naturally (DEPTH is a power of 2).
  always_ff @(posedge clk) begin
    // NOTE: state is updated with <= so every register sees pre-edge values of the others.
    if (!reset_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
    end
  end

  // Storage array write port.
  always_ff @(posedge clk) begin
    // NOTE: storage is not reset; emptiness is tracked by the pointers, so stale words are never read.
    if (push) mem[wr_ptr] <= push_data;
  end

  assign pop_data = mem[rd_ptr];
  assign count    = count_q;
  assign empty    = (count_q == '0);
  assign full     = (count_q == CNT_W'(DEPTH));

endmodule

// File: rtl/avalon_word_copier.sv
// Avalon-MM master that copies a block of 32-bit words in FIFO-sized chunks:
// read a chunk into the local FIFO, then write it out, over one master port.
module avalon_word_copier
  import avalon_copier_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int LEN_W      = 15,
  parameter int FIFO_DEPTH = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  output logic              avm_write,
  output logic [3:0]        avm_byteenable,
  output logic [31:0]       avm_writedata,
  input  logic              avm_waitrequest,
  input  logic [31:0]       avm_readdata,
  input  logic              avm_readdatavalid
);

  localparam int                CNT_W      = $clog2(FIFO_DEPTH + 1);
  localparam logic [ADDR_W-1:0] WORD_STEP  = ADDR_W'(BYTES_PER_WORD);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(BYTES_PER_WORD - 1);
  localparam logic [LEN_W-1:0]  DEPTH_LEN  = LEN_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]  DEPTH_CNT  = CNT_W'(FIFO_DEPTH);

  // Words in the next chunk: whatever is left, capped at the FIFO depth.
  function automatic logic [CNT_W-1:0] chunk_of(input logic [LEN_W-1:0] words);
    return (words >= DEPTH_LEN) ? DEPTH_CNT : words[CNT_W-1:0];
  endfunction

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dst_q, dst_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [CNT_W-1:0]  chunk_q, chunk_d;
  logic [CNT_W-1:0]  issued_q, issued_d;
  logic [CNT_W-1:0]  written_q, written_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              read_q, read_d;
  logic              write_q, write_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic              fifo_push, fifo_pop, fifo_empty, fifo_full;
  logic [CNT_W-1:0]  fifo_count, received_next;
  logic [31:0]       fifo_head;
  logic [LEN_W-1:0]  rem_left;

  // Read data is only captured while a chunk is being fetched; anything else is stray.
  assign fifo_push     = avm_readdatavalid && (state_q == RD || state_q == RD_WAIT) && !fifo_full;
  assign fifo_pop      = write_q && !avm_waitrequest && !fifo_empty;
  // The FIFO is empty at every chunk start, so its occupancy is the received-word count.
  assign received_next = fifo_count + CNT_W'(fifo_push);
  assign rem_left      = rem_q - LEN_W'(chunk_q);

  copier_fifo #(
    .DATA_W (32),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (fifo_push),
    .push_data (avm_readdata),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .empty     (fifo_empty),
    .full      (fifo_full),
    .count     (fifo_count)
  );

  // Next-state and next-output decode; master outputs are computed here and registered below.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
    state_d   = state_q;
    src_d     = src_q;
    dst_d     = dst_q;
    rem_d     = rem_q;
    chunk_d   = chunk_q;
    issued_d  = issued_q;
    written_d = written_q;
    addr_d    = addr_q;
    read_d    = 1'b0;
    write_d   = 1'b0;
    busy_d    = 1'b1;
    done_d    = 1'b0;

    unique case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          src_d     = src_addr & ALIGN_MASK;
          dst_d     = dst_addr & ALIGN_MASK;
          rem_d     = len;
          issued_d  = '0;
          written_d = '0;
          if (len == '0) begin
            state_d = FIN;
            done_d  = 1'b1;
          end else begin
            state_d = RD;
            chunk_d = chunk_of(len);
            read_d  = 1'b1;
            addr_d  = src_addr & ALIGN_MASK;
            busy_d  = 1'b1;
          end
        end
      end

      RD: begin
        read_d = read_q;
        if (read_q && !avm_waitrequest) begin
          src_d    = src_q + WORD_STEP;
          issued_d = issued_q + CNT_W'(1);
          if (issued_q + CNT_W'(1) < chunk_q) begin
            addr_d = src_q + WORD_STEP;
          end else begin
            read_d = 1'b0;
            if (received_next == chunk_q) begin
              state_d = WR;
              write_d = 1'b1;
              addr_d  = dst_q;
            end else begin
              state_d = RD_WAIT;
            end
          end
        end
      end

      RD_WAIT: begin
        if (received_next == chunk_q) begin
          state_d = WR;
          write_d = 1'b1;
          addr_d  = dst_q;
        end
      end

      WR: begin
        write_d = 1'b1;
        if (!avm_waitrequest) begin
          dst_d     = dst_q + WORD_STEP;
          written_d = written_q + CNT_W'(1);
          if (written_q + CNT_W'(1) == chunk_q) begin
            write_d   = 1'b0;
            rem_d     = rem_left;
            issued_d  = '0;
            written_d = '0;
            if (rem_left == '0) begin
              state_d = FIN;
              busy_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              state_d = RD;
              chunk_d = chunk_of(rem_left);
              read_d  = 1'b1;
              addr_d  = src_q;
            end
          end else begin
            addr_d = dst_q + WORD_STEP;
          end
        end
      end

      FIN: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State, datapath and registered master outputs; synchronous abort on reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      rem_q     <= '0;
      chunk_q   <= '0;
      issued_q  <= '0;
      written_q <= '0;
      addr_q    <= '0;
      read_q    <= 1'b0;
      write_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      src_q     <= src_d;
      dst_q     <= dst_d;
      rem_q     <= rem_d;
      chunk_q   <= chunk_d;
      issued_q  <= issued_d;
      written_q <= written_d;
      addr_q    <= addr_d;
      read_q    <= read_d;
      write_q   <= write_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign avm_address    = addr_q;
  assign avm_read       = read_q;
  assign avm_write      = write_q;
  assign avm_byteenable = BYTEENABLE_ALL;
  assign avm_writedata  = fifo_head;

endmodule

// File: tb/tb_avalon_word_copier.sv
// Self-checking bench: randomized Avalon slave with memory model, write scoreboard
// built from the source words at command time, and a negedge monitor.
module tb_avalon_word_copier;

  localparam int FIFO_DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset_n, start;
  logic [15:0] src_addr, dst_addr;
  logic [14:0] len;
  logic        busy, done, avm_read, avm_write;
  logic [15:0] avm_address;
  logic [3:0]  avm_byteenable;
  logic [31:0] avm_writedata, avm_readdata;
  logic        avm_waitrequest, avm_readdatavalid;

  avalon_word_copier #(.ADDR_W(16), .LEN_W(15), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .start             (start),
    .src_addr          (src_addr),
    .dst_addr          (dst_addr),
    .len               (len),
    .busy              (busy),
    .done              (done),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_write         (avm_write),
    .avm_byteenable    (avm_byteenable),
    .avm_writedata     (avm_writedata),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid)
  );

  always #5 clk = ~clk;

  typedef struct { int due; logic [31:0] data; } rsp_t;
  typedef struct { logic [15:0] addr; logic [31:0] data; } wr_t;

  logic [31:0] mem [16384];
  rsp_t        pend[$];
  wr_t         exp_q[$];
  int          exp_runs[$], runs[$];
  int          checks = 0, errors = 0;
  int          cyc = 0, latency = 1, wait_pct = 0;
  int          reads_acc, writes_acc, out_cnt, max_out, rd_run;
  logic [15:0] exp_rd_addr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Slave driver: random stalls, in-order read data after the configured latency.
  initial begin
    avm_waitrequest   = 1'b0;
    avm_readdatavalid = 1'b0;
    avm_readdata      = '0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      avm_waitrequest = (wait_pct > 0) && ($urandom_range(0, 99) < wait_pct);
      if (pend.size() > 0 && pend[0].due <= cyc) begin
        avm_readdatavalid = 1'b1;
        avm_readdata      = pend.pop_front().data;
      end else begin
        avm_readdatavalid = 1'b0;
        avm_readdata      = $urandom;
      end
    end
  end

  // Monitor: protocol checks, read address order, write scoreboard, chunk runs.
  initial begin
    logic        prev_stall = 1'b0, prev_rd = 1'b0, prev_wr = 1'b0;
    logic [15:0] prev_addr = '0;
    logic [31:0] prev_data = '0;
    wr_t         e;
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (avm_read || avm_write) check("rd_wr_exclusive", avm_read & avm_write, 0);
        if (prev_stall) begin
          check("hold_address", avm_address, prev_addr);
          check("hold_read", avm_read, prev_rd);
          check("hold_write", avm_write, prev_wr);
          if (prev_wr) check("hold_writedata", avm_writedata, prev_data);
        end
        if (avm_readdatavalid && out_cnt > 0) out_cnt--;
        if (avm_read && !avm_waitrequest) begin
          check("read_address", avm_address, exp_rd_addr);
          exp_rd_addr += 16'd4;
          pend.push_back('{cyc + latency, mem[avm_address[15:2]]});
          reads_acc++;
          rd_run++;
          out_cnt++;
          if (out_cnt > max_out) max_out = out_cnt;
        end
        if (avm_write && !avm_waitrequest) begin
          if (rd_run > 0) begin
            runs.push_back(rd_run);
            rd_run = 0;
          end
          if (exp_q.size() == 0) begin
            check("unexpected_write", 1, 0);
          end else begin
            e = exp_q.pop_front();
            check("write_address", avm_address, e.addr);
            check("write_data", avm_writedata, e.data);
          end
          mem[avm_address[15:2]] = avm_writedata;
          writes_acc++;
        end
      end
      prev_stall = reset_n && (avm_read || avm_write) && avm_waitrequest;
      prev_rd    = avm_read;
      prev_wr    = avm_write;
      prev_addr  = avm_address;
      prev_data  = avm_writedata;
    end
  end

  // Build the reference outcome of a copy and issue the command for one cycle.
  task automatic start_copy(input logic [15:0] s, input logic [15:0] d, input int n,
                            input int lat, input int wpct);
    int rem;
    latency = lat;
    wait_pct = wpct;
    exp_q.delete();
    runs.delete();
    exp_runs.delete();
    reads_acc = 0; writes_acc = 0; out_cnt = 0; max_out = 0; rd_run = 0;
    exp_rd_addr = s;
    for (int i = 0; i < n; i++) begin
      logic [15:0] sa, da;
      sa = s + 16'(4 * i);
      da = d + 16'(4 * i);
      exp_q.push_back('{da, mem[sa[15:2]]});
    end
    rem = n;
    while (rem > 0) begin
      exp_runs.push_back(rem < FIFO_DEPTH ? rem : FIFO_DEPTH);
      rem -= FIFO_DEPTH;
    end
    @(negedge clk);
    start    = 1'b1;
    src_addr = s | 16'($urandom_range(0, 3));
    dst_addr = d;
    len      = 15'(n);
    @(negedge clk);
    start    = 1'b0;
    src_addr = 16'($urandom);
    dst_addr = 16'($urandom);
    len      = 15'($urandom);
  endtask

  // Wait (bounded) for done, optionally poking start while busy, then check the outcome.
  task automatic finish_copy(input bit poke, input int n_words, output int dc);
    int  n = 1;
    bit  seen = 0;
    while (n < 5000) begin
      if (done) begin
        seen = 1;
        break;
      end
      if (poke && n == 4) begin
        check("poke_while_busy", busy, 1);
        start    = 1'b1;
        src_addr = 16'h0040;
        dst_addr = 16'h0080;
        len      = 15'd3;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    dc = n;
    check("done_seen", seen, 1);
    check("busy_low_with_done", busy, 0);
    check("reads_total", reads_acc, n_words);
    check("writes_total", writes_acc, n_words);
    check("scoreboard_drained", exp_q.size(), 0);
    check("max_outstanding_ok", max_out <= FIFO_DEPTH, 1);
    check("chunk_count", runs.size(), exp_runs.size());
    for (int i = 0; i < runs.size() && i < exp_runs.size(); i++)
      check("chunk_reads", runs[i], exp_runs[i]);
    @(negedge clk);
    check("done_one_cycle", done, 0);
  endtask

  initial begin
    int dc, n, busy_seen;
    reset_n = 1'b0; start = 1'b0; src_addr = '0; dst_addr = '0; len = '0;
    for (int i = 0; i < 16384; i++) mem[i] = (i < 64) ? 32'hA500_0000 + 32'(i) : $urandom;
    repeat (3) @(negedge clk);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_read", avm_read, 0);
    check("reset_write", avm_write, 0);
    check("reset_address", avm_address, 0);
    check("byteenable", avm_byteenable, 4'hF);
    reset_n = 1'b1;

    // Single chunk, zero-wait, latency 1.
    start_copy(16'h0000, 16'h1000, 5, 1, 0);
    check("busy_after_start", busy, 1);
    check("read_after_start", avm_read, 1);
    finish_copy(0, 5, dc);
    check("done_latency_len5", dc, 12);

    // Three chunks: 8, 8, 4.
    start_copy(16'h2000, 16'h4000, 20, 2, 0);
    finish_copy(0, 20, dc);

    // Random stalls with latency 3.
    start_copy(16'h5000, 16'h6000, 13, 3, 50);
    finish_copy(0, 13, dc);

    // Zero-length command.
    start_copy(16'h0100, 16'h0200, 0, 1, 0);
    finish_copy(0, 0, dc);
    check("done_latency_len0", dc, 1);

    // Start pulsed while busy must be ignored, and must not launch a copy afterwards.
    start_copy(16'h7000, 16'h7800, 12, 2, 30);
    finish_copy(1, 12, dc);
    busy_seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (busy || avm_read || avm_write) busy_seen = 1;
    end
    check("no_relaunch", busy_seen, 0);

    // Destination wraps around the top of the address space.
    start_copy(16'h8000, 16'hFFF0, 8, 2, 25);
    finish_copy(0, 8, dc);

    // Abort mid-transfer, then a fresh copy with a stray readdatavalid beforehand.
    start_copy(16'h0400, 16'h0800, 10, 3, 0);
    n = 0;
    while (reads_acc < 3 && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("third_read_seen", reads_acc >= 3, 1);
    @(negedge clk);
    reset_n = 1'b0;
    @(negedge clk);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    check("abort_read", avm_read, 0);
    check("abort_write", avm_write, 0);
    check("abort_address", avm_address, 0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    pend.push_back('{cyc + 1, 32'hDEAD_BEEF});
    repeat (3) @(negedge clk);
    start_copy(16'h0C00, 16'h0E00, 2, 1, 0);
    finish_copy(0, 2, dc);

    // Randomized copies between disjoint halves of memory.
    for (int t = 0; t < 4; t++) begin
      int          nw;
      logic [15:0] s, d;
      nw = $urandom_range(1, 40);
      s  = 16'($urandom_range(0, 8000) * 4);
      d  = 16'h8000 + 16'($urandom_range(0, 7900) * 4);
      start_copy(s, d, nw, $urandom_range(1, 4), $urandom_range(0, 60));
      finish_copy(0, nw, dc);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
